// File: rtl/fpga_config_loader_pkg.sv
// Shared types and constants for the FPGA configuration loader: FSM states,
// LE config word field layout, default preamble and output-select codes.
package fpga_config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    localparam int          WORD_W            = 32;
    localparam int          SYNC_W            = 16;
    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;

    // LE config word layout: [31:16] lut, [15:8] lut inputs, then four 2-bit output selects.
    localparam int LUT_LSB    = 16;
    localparam int LUT_W      = 16;
    localparam int LUTINS_LSB = 8;
    localparam int LUTINS_W   = 8;
    localparam int NORTH_LSB  = 6;
    localparam int EAST_LSB   = 4;
    localparam int WEST_LSB   = 2;
    localparam int SOUTH_LSB  = 0;
    localparam int SEL_W      = 2;

    localparam logic [1:0] CONF_OFF  = 2'b00;
    localparam logic [1:0] CONF_LUT  = 2'b01;
    localparam logic [1:0] CONF_REG  = 2'b10;
    localparam logic [1:0] CONF_PASS = 2'b11;

endpackage

// File: rtl/fpga_cfg_shifter.sv
// 32-bit MSB-first deserialiser with bit counter; word_valid marks the cycle the
// 32nd bit is consumed and word_next carries the completed word on that cycle.
module fpga_cfg_shifter
    import fpga_config_loader_pkg::*;
#(
    parameter int WIN_W = SYNC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic              i_bit,
    output logic [WIN_W-1:0]  o_window,
    output logic [WORD_W-1:0] o_word_next,
    output logic              o_word_valid
);

    logic [WORD_W-1:0] r_shift;
    logic [4:0]        r_cnt;

    assign o_word_next  = {r_shift[WORD_W-2:0], i_bit};
    assign o_window     = r_shift[WIN_W-1:0];
    assign o_word_valid = i_shift_en && !i_clear && (r_cnt == 5'd31);

    // A clear coinciding with a consumed bit restarts with that bit as the first one.
    always_ff @(posedge clk) begin
        if (rst || (i_clear && !i_shift_en)) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= {{(WORD_W-1){1'b0}}, i_bit};
            r_cnt   <= 5'd1;
        end else if (i_shift_en) begin
            r_shift <= o_word_next;
            r_cnt   <= r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Serial bitstream loader: finds the preamble, writes R*C LE config words
// row-major to the grid, then verifies an XOR checksum before committing.
module fpga_config_loader
    import fpga_config_loader_pkg::*;
#(
    parameter int          R         = 5,
    parameter int          C         = 5,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ser_data,
    input  logic                   ser_valid,
    output logic                   ser_ready,
    output logic                   cfg_we,
    output logic [$clog2(R*C)-1:0] cfg_addr,
    output logic [31:0]            cfg_word,
    output logic                   cfg_commit,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output state_e                 dbg_state
);

    localparam int             AW       = $clog2(R*C);
    localparam logic [AW-1:0]  LAST_IDX = AW'(R*C-1);

    state_e          r_state;
    state_e          w_next_state;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_csum;
    logic            r_cfg_we;
    logic [AW-1:0]   r_cfg_addr;
    logic [31:0]     r_cfg_word;
    logic            r_cfg_commit;

    logic            w_consume;
    logic            w_clear;
    logic            w_shift_en;
    logic [15:0]     w_window;
    logic [31:0]     w_word_next;
    logic            w_word_valid;
    logic [15:0]     w_window_next;

    // Handshake: a bit moves only when ser_valid && ser_ready; ser_ready depends on state alone.
    assign ser_ready     = (r_state == ST_SYNC) || (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_consume     = ser_valid && ser_ready;
    assign w_window_next = {w_window[14:0], ser_data};

    fpga_cfg_shifter #(.WIN_W(16)) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_shift_en   (w_shift_en),
        .i_bit        (ser_data),
        .o_window     (w_window),
        .o_word_next  (w_word_next),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift_en   = w_consume;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SYNC;
                    w_clear      = 1'b1;
                end
            end
            ST_SYNC: begin
                if (start) begin
                    w_clear = 1'b1;
                end else if (w_consume && (w_window_next == SYNC_WORD)) begin
                    // The last preamble bit must not land in the first config word.
                    w_next_state = ST_LOAD;
                    w_clear      = 1'b1;
                    w_shift_en   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_word_valid && (r_idx == LAST_IDX)) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_word_valid) begin
                    w_next_state = (w_word_next == r_csum) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_next_state = ST_SYNC;
                    w_clear      = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_csum       <= '0;
            r_cfg_we     <= 1'b0;
            r_cfg_addr   <= '0;
            r_cfg_word   <= '0;
            r_cfg_commit <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cfg_we     <= 1'b0;
            r_cfg_commit <= 1'b0;
            if ((r_state == ST_SYNC) && (w_next_state == ST_LOAD)) begin
                r_idx  <= '0;
                r_csum <= '0;
            end
            if ((r_state == ST_LOAD) && w_word_valid) begin
                r_cfg_we   <= 1'b1;
                r_cfg_addr <= r_idx;
                r_cfg_word <= w_word_next;
                r_csum     <= r_csum ^ w_word_next;
                r_idx      <= r_idx + 1'b1;
            end
            if ((r_state == ST_CHECK) && (w_next_state == ST_DONE)) begin
                r_cfg_commit <= 1'b1;
            end
        end
    end

    assign cfg_we     = r_cfg_we;
    assign cfg_addr   = r_cfg_addr;
    assign cfg_word   = r_cfg_word;
    assign cfg_commit = r_cfg_commit;
    assign cfg_done   = (r_state == ST_DONE);
    assign cfg_error  = (r_state == ST_ERROR);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: bit-serial driver, captured strobe
// queues checked against hand-computed words, and a downstream LE register bank.
module tb_fpga_config_loader;
    import fpga_config_loader_pkg::*;

    localparam logic [31:0] GOOD_CSUM = 32'h0001_0018;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ser_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_word;
    logic        cfg_commit;
    logic        cfg_done;
    logic        cfg_error;
    state_e      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int commit_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_word_q[$];
    logic [4:0]  got_addr_q[$];
    logic [31:0] le_bank [0:24];

    fpga_config_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_word   (cfg_word),
        .cfg_commit (cfg_commit),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor and downstream grid bank, sampled mid-cycle.
    always @(negedge clk) begin
        if (cfg_we || cfg_commit) check("we_commit_excl", 32'(cfg_we & cfg_commit), 32'd0);
        if (cfg_we) begin
            got_word_q.push_back(cfg_word);
            got_addr_q.push_back(cfg_addr);
            if (cfg_addr < 5'd25) le_bank[cfg_addr] = cfg_word;
        end
        if (cfg_commit) commit_cnt++;
    end

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        ser_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        int  guard = 0;
        bit  sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            if (gaps && ($urandom_range(1, 0) == 0)) begin
                ser_valid = 1'b0;
            end else begin
                ser_valid = 1'b1;
                ser_data  = b;
                sent      = ser_ready;
            end
            guard++;
            if (!sent && guard > 200) begin
                check("ready_wait", 32'(ser_ready), 32'd1);
                sent = 1'b1;
            end
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    task automatic end_drive(input int cycles);
        @(negedge clk);
        ser_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic clear_capture();
        got_word_q.delete();
        got_addr_q.delete();
        commit_cnt = 0;
    endtask

    task automatic send_words(input int n, input bit gaps, input bit mid_start);
        for (int k = 0; k < n; k++) begin
            if (mid_start && k == 12) pulse_start();
            send_bits(32'h0001_0000 + 32'(k), 32, gaps);
        end
    endtask

    task automatic check_result(input string tag, input bit ok);
        int n;
        check({tag, "_we_count"}, 32'(got_word_q.size()), 32'd25);
        n = (got_word_q.size() < 25) ? got_word_q.size() : 25;
        for (int k = 0; k < n; k++) begin
            check({tag, "_addr"}, 32'(got_addr_q[k]), 32'(k));
            check({tag, "_word"}, got_word_q[k], exp_q[k]);
        end
        check({tag, "_commit_cnt"}, 32'(commit_cnt), ok ? 32'd1 : 32'd0);
        check({tag, "_done"}, 32'(cfg_done), ok ? 32'd1 : 32'd0);
        check({tag, "_error"}, 32'(cfg_error), ok ? 32'd0 : 32'd1);
        check({tag, "_ready"}, 32'(ser_ready), 32'd0);
        check({tag, "_bank0"}, le_bank[0], 32'h0001_0000);
        check({tag, "_bank24"}, le_bank[24], 32'h0001_0018);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ser_data = 1'b0; ser_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            exp_q.push_back(32'h0001_0000 + 32'(k));
            le_bank[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_ready", 32'(ser_ready), 32'd0);
        check("rst_we", 32'(cfg_we), 32'd0);
        check("rst_commit", 32'(cfg_commit), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_error", 32'(cfg_error), 32'd0);
        check("rst_addr", 32'(cfg_addr), 32'd0);
        check("rst_word", cfg_word, 32'd0);

        // Clean load.
        clear_capture();
        pulse_start();
        check("sync_ready", 32'(ser_ready), 32'd1);
        send_bits(32'(16'hA5C3), 16, 1'b0);
        send_words(25, 1'b0, 1'b0);
        send_bits(GOOD_CSUM, 32, 1'b0);
        end_drive(4);
        check_result("good", 1'b1);

        // Restart from DONE, with an ignored start mid-LOAD.
        for (int k = 0; k < 25; k++) le_bank[k] = '0;
        clear_capture();
        pulse_start();
        check("restart_done", 32'(cfg_done), 32'd0);
        check("restart_ready", 32'(ser_ready), 32'd1);
        send_bits(32'(16'hA5C3), 16, 1'b0);
        send_words(25, 1'b0, 1'b1);
        send_bits(GOOD_CSUM, 32, 1'b0);
        end_drive(4);
        check_result("midstart", 1'b1);

        // Bad checksum.
        clear_capture();
        pulse_start();
        send_bits(32'(16'hA5C3), 16, 1'b0);
        send_words(25, 1'b0, 1'b0);
        send_bits(GOOD_CSUM ^ 32'd1, 32, 1'b0);
        end_drive(4);
        check_result("badcsum", 1'b0);

        // Noise ahead of the preamble.
        clear_capture();
        pulse_start();
        send_bits(32'(16'h1234), 16, 1'b0);
        send_bits(32'b101, 3, 1'b0);
        send_bits(32'(16'hA5C3), 16, 1'b0);
        send_words(25, 1'b0, 1'b0);
        send_bits(GOOD_CSUM, 32, 1'b0);
        end_drive(4);
        check_result("noise", 1'b1);

        // Random valid gaps throughout.
        clear_capture();
        pulse_start();
        send_bits(32'(16'hA5C3), 16, 1'b1);
        send_words(25, 1'b1, 1'b0);
        send_bits(GOOD_CSUM, 32, 1'b1);
        end_drive(4);
        check_result("gaps", 1'b1);

        // Reset after 10 words, with valid still asserted.
        clear_capture();
        pulse_start();
        send_bits(32'(16'hA5C3), 16, 1'b0);
        send_words(10, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mrst_ready", 32'(ser_ready), 32'd0);
        check("mrst_we", 32'(cfg_we), 32'd0);
        check("mrst_addr", 32'(cfg_addr), 32'd0);
        check("mrst_word", cfg_word, 32'd0);
        check("mrst_done", 32'(cfg_done), 32'd0);
        check("mrst_error", 32'(cfg_error), 32'd0);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        repeat (40) @(negedge clk);
        ser_valid = 1'b0;
        check("mrst_we_count", 32'(got_word_q.size()), 32'd10);
        check("mrst_idle_after", 32'(dbg_state), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 Parameter R, default 5: LE grid rows.
REQ-002 Parameter C, default 5: LE grid columns.
REQ-003 Parameter SYNC_WORD, default 16'hA5C3: bitstream preamble.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that arms a new load.
REQ-007 ser_data  input  1  serial bitstream bit, MSB-first.
REQ-008 ser_valid  input  1  ser_data valid this cycle.
REQ-009 ser_ready  output  1  loader accepts a bit this cycle.
REQ-010 cfg_we  output  1  one-cycle write strobe for an LE config word.
REQ-011 cfg_addr  output  $clog2(R*C)  LE index, row-major (i*C+j).
REQ-012 cfg_word  output  32  LE config: [31:16] lut, [15:8] lutIns {in3,in2,in1,in0}, [7:6] north, [5:4] east, [3:2] west, [1:0] south output conf.
REQ-013 cfg_commit  output  1  one-cycle pulse: all words loaded and checksum good.
REQ-014 cfg_done  output  1  level: last load succeeded.
REQ-015 cfg_error  output  1  level: last load failed checksum.

Function
REQ-016 A bit is consumed only on a cycle with ser_valid && ser_ready; all other cycles leave the shift state unchanged.
REQ-017 States: IDLE, SYNC, LOAD, CHECK, DONE, ERROR.
REQ-018 IDLE: ser_ready=0; start -> SYNC.
REQ-019 SYNC: ser_ready=1; bits shift into a 16-bit window; the window equalling SYNC_WORD after a consumed bit -> LOAD with the bit counter, address and checksum cleared.
REQ-020 LOAD: ser_ready=1; 32 consumed bits form one word; on the 32nd bit, cfg_we=1 the next cycle with cfg_addr=current index and cfg_word=assembled word.
REQ-021 Index increments after each word; after word R*C-1, the next state is CHECK with no cfg_we for a further word.
REQ-022 Checksum accumulator = XOR of all R*C 32-bit words.
REQ-023 CHECK: ser_ready=1; 32 consumed bits form the received checksum; equal -> DONE with cfg_commit pulsed once; unequal -> ERROR.
REQ-024 DONE: ser_ready=0, cfg_done=1. ERROR: ser_ready=0, cfg_error=1. Both hold until start.
REQ-025 start in DONE or ERROR clears cfg_done/cfg_error and -> SYNC; start in SYNC restarts sync search with the window cleared; start in LOAD/CHECK is ignored.
REQ-026 A ser_valid gap of any length mid-word does not corrupt the word.
REQ-027 cfg_we and cfg_commit are never high on the same cycle; cfg_addr/cfg_word hold their last value when cfg_we=0.

Reset
REQ-028 rst aborts any load in the same cycle and forces IDLE, ser_ready=0, cfg_we=0, cfg_commit=0, cfg_done=0, cfg_error=0, cfg_addr=0, cfg_word=0, counters and checksum=0.
REQ-029 rst has priority over start and ser_valid.

Structure
REQ-030 The shared package holds the state enum, the 32-bit word field offsets/widths, SYNC_WORD default, and the conf-code constants for the 2-bit output selects.
REQ-031 A single sub-module, fpga_cfg_shifter (32-bit MSB-first deserialiser with bit counter and word_valid pulse), is reused by SYNC-window, LOAD and CHECK paths; the FSM stays in the top.
REQ-032 Downstream, a per-LE register bank in the grid captures cfg_word when cfg_we && cfg_addr==i*C+j.

Verification
REQ-033 Reset mid-LOAD after 10 words -> next cycle IDLE, all outputs 0, no further cfg_we.
REQ-034 start, 16'hA5C3, 25 words w_k=32'h0001_0000+k, checksum XOR(w_0..w_24) -> 25 cfg_we strobes, addr 0..24, words match, cfg_commit once, cfg_done=1.
REQ-035 Same stream with checksum bit 0 flipped -> 25 strobes, no cfg_commit, cfg_error=1, ser_ready=0.
REQ-036 Noise 16'h1234 then 16'hA5C3 preceded by bits 1,0,1 -> sync found only at the true SYNC_WORD; first cfg_we at addr 0.
REQ-037 ser_valid toggled randomly 50% throughout the REQ-034 stream -> identical strobes/words/commit.
REQ-038 start asserted mid-LOAD -> ignored; start in DONE -> cfg_done clears, ser_ready=1, new load succeeds.
